// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: address packing, data width and arbiter state encoding.
package sdram_pkg;

   localparam int RowWidth  = 12;
   localparam int ColWidth  = 8;
   localparam int BankWidth = 2;
   localparam int AddrWidth = RowWidth + ColWidth + BankWidth;
   localparam int DataWidth = 16;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   // Builds a controller address from its fields: {row, col, bank}.
   function automatic logic [AddrWidth-1:0] pack_addr(
      input logic [RowWidth-1:0]  row,
      input logic [ColWidth-1:0]  col,
      input logic [BankWidth-1:0] bank
   );
      return {row, col, bank};
   endfunction

endpackage

// File: rtl/sdram_arbiter_rr.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);
   import sdram_pkg::*;

   localparam int IdxWidth = $clog2(N);

   int                  pos_s;
   logic [IdxWidth-1:0] pos_idx_s;
   logic                found_s;

   // Scan every port once, starting just after the previous winner.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      found_s   = 1'b0;
      pos_s     = 0;
      pos_idx_s = '0;
      for (int i = 1; i <= N; i++) begin
         pos_s     = (int'(last) + i) % N;
         pos_idx_s = IdxWidth'(pos_s);
         if (!found_s && req[pos_idx_s]) begin
            found_s        = 1'b1;
            gnt[pos_idx_s] = 1'b1;
            gnt_idx        = pos_idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin front end sharing one sdram_ctrl among NumPorts clients,
// one transaction in flight, with a completion timeout.
module sdram_arbiter #(
   parameter int NumPorts      = 2,
   parameter int AddrWidth     = sdram_pkg::AddrWidth,
   parameter int DataWidth     = sdram_pkg::DataWidth,
   parameter int TimeoutCycles = 1024
) (
   input  logic                                i_sys_clk,
   input  logic                                i_rst,
   input  logic [NumPorts-1:0]                 i_req_valid,
   input  logic [NumPorts-1:0]                 i_req_we,
   input  logic [NumPorts-1:0][AddrWidth-1:0]  i_req_addr,
   input  logic [NumPorts-1:0][DataWidth-1:0]  i_req_wdata,
   output logic [NumPorts-1:0]                 o_req_ready,
   output logic [NumPorts-1:0]                 o_rd_valid,
   output logic [DataWidth-1:0]                o_rd_data,
   output logic [NumPorts-1:0]                 o_err,
   output logic                                o_ctrl_wr_req,
   output logic                                o_ctrl_rd_req,
   output logic [AddrWidth-1:0]                o_ctrl_wr_addr,
   output logic [AddrWidth-1:0]                o_ctrl_rd_addr,
   output logic [DataWidth-1:0]                o_ctrl_wr_data,
   input  logic                                i_ctrl_ready,
   input  logic                                i_ctrl_done,
   input  logic [DataWidth-1:0]                i_ctrl_rd_data
);
   import sdram_pkg::*;

   localparam int IdxWidth = $clog2(NumPorts);
   localparam int CntWidth = $clog2(TimeoutCycles);
   localparam logic [CntWidth-1:0] CntMax   = CntWidth'(TimeoutCycles - 1);
   localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1'b1);
   localparam logic [IdxWidth-1:0] LastInit = IdxWidth'(NumPorts - 1);
   localparam logic [NumPorts-1:0] OneHot0  = {{(NumPorts-1){1'b0}}, 1'b1};

   arb_state_e           state_r;
   arb_state_e           state_s;
   logic [IdxWidth-1:0]  last_grant_r;
   logic [IdxWidth-1:0]  owner_r;
   logic                 we_r;
   logic [CntWidth-1:0]  cnt_r;

   logic [NumPorts-1:0]  gnt_s;
   logic [IdxWidth-1:0]  gnt_idx_s;
   logic [NumPorts-1:0]  ready_s;
   logic                 accept_s;
   logic                 done_s;
   logic                 timeout_s;

   logic [NumPorts-1:0]  rd_valid_r;
   logic [DataWidth-1:0] rd_data_r;
   logic [NumPorts-1:0]  err_r;
   logic                 ctrl_wr_req_r;
   logic                 ctrl_rd_req_r;
   logic [AddrWidth-1:0] ctrl_wr_addr_r;
   logic [AddrWidth-1:0] ctrl_rd_addr_r;
   logic [DataWidth-1:0] ctrl_wr_data_r;

   rr_arbiter #(
      .N (NumPorts)
   ) u_rr (
      .req     (i_req_valid),
      .last    (last_grant_r),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // Next-state logic; ready is the picker's grant, only in IDLE with the controller free.
   always_comb begin
      state_s   = state_r;
      ready_s   = '0;
      accept_s  = 1'b0;
      done_s    = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (!i_rst && i_ctrl_ready && (|i_req_valid)) begin
               ready_s  = gnt_s;
               accept_s = 1'b1;
               state_s  = ARB_ISSUE;
            end else begin
               state_s = ARB_IDLE;
            end
         end
         ARB_ISSUE: begin
            state_s = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (i_ctrl_done) begin
               done_s  = 1'b1;
               state_s = ARB_IDLE;
            end else if (cnt_r == CntMax) begin
               timeout_s = 1'b1;
               state_s   = ARB_IDLE;
            end else begin
               state_s = ARB_WAIT;
            end
         end
         default: begin
            state_s = ARB_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state_r <= ARB_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Transaction latches, timeout counter, command pulses and return routing.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         last_grant_r   <= LastInit;
         owner_r        <= '0;
         we_r           <= 1'b0;
         cnt_r          <= '0;
         rd_valid_r     <= '0;
         rd_data_r      <= '0;
         err_r          <= '0;
         ctrl_wr_req_r  <= 1'b0;
         ctrl_rd_req_r  <= 1'b0;
         ctrl_wr_addr_r <= '0;
         ctrl_rd_addr_r <= '0;
         ctrl_wr_data_r <= '0;
      end else begin
         ctrl_wr_req_r <= 1'b0;
         ctrl_rd_req_r <= 1'b0;
         rd_valid_r    <= '0;
         err_r         <= '0;

         // Accept: latch the request so the pulse appears in the ISSUE cycle.
         if (accept_s) begin
            owner_r      <= gnt_idx_s;
            we_r         <= i_req_we[gnt_idx_s];
            last_grant_r <= gnt_idx_s;
            if (i_req_we[gnt_idx_s]) begin
               ctrl_wr_req_r  <= 1'b1;
               ctrl_wr_addr_r <= i_req_addr[gnt_idx_s];
               ctrl_wr_data_r <= i_req_wdata[gnt_idx_s];
            end else begin
               ctrl_rd_req_r  <= 1'b1;
               ctrl_rd_addr_r <= i_req_addr[gnt_idx_s];
            end
         end

         // Counter starts from zero on the first WAIT cycle and saturates.
         if (state_r == ARB_ISSUE) begin
            cnt_r <= '0;
         end else if ((state_r == ARB_WAIT) && !i_ctrl_done && (cnt_r != CntMax)) begin
            cnt_r <= cnt_r + CntOne;
         end

         if (done_s && !we_r) begin
            rd_valid_r <= OneHot0 << owner_r;
            rd_data_r  <= i_ctrl_rd_data;
         end

         // A timed-out read still returns a (zero) word so the client is not left waiting.
         if (timeout_s) begin
            err_r <= OneHot0 << owner_r;
            if (!we_r) begin
               rd_valid_r <= OneHot0 << owner_r;
               rd_data_r  <= '0;
            end
         end
      end
   end

   assign o_req_ready    = ready_s;
   assign o_rd_valid     = rd_valid_r;
   assign o_rd_data      = rd_data_r;
   assign o_err          = err_r;
   assign o_ctrl_wr_req  = ctrl_wr_req_r;
   assign o_ctrl_rd_req  = ctrl_rd_req_r;
   assign o_ctrl_wr_addr = ctrl_wr_addr_r;
   assign o_ctrl_rd_addr = ctrl_rd_addr_r;
   assign o_ctrl_wr_data = ctrl_wr_data_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized bench for sdram_arbiter, acting as both clients and controller.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   localparam int NP = 2;
   localparam int AW = 22;
   localparam int DW = 16;
   localparam int TO = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NP-1:0]           valid;
   logic [NP-1:0]           we;
   logic [NP-1:0][AW-1:0]   addr;
   logic [NP-1:0][DW-1:0]   wdata;
   logic [NP-1:0]           o_req_ready;
   logic [NP-1:0]           o_rd_valid;
   logic [DW-1:0]           o_rd_data;
   logic [NP-1:0]           o_err;
   logic                    o_ctrl_wr_req;
   logic                    o_ctrl_rd_req;
   logic [AW-1:0]           o_ctrl_wr_addr;
   logic [AW-1:0]           o_ctrl_rd_addr;
   logic [DW-1:0]           o_ctrl_wr_data;
   logic                    ctrl_ready;
   logic                    done;
   logic [DW-1:0]           crd;

   int n_cmp = 0;
   int n_err = 0;
   int last_g;

   sdram_arbiter #(
      .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
   ) dut (
      .i_sys_clk(clk), .i_rst(rst),
      .i_req_valid(valid), .i_req_we(we), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_req_ready(o_req_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_err(o_err),
      .o_ctrl_wr_req(o_ctrl_wr_req), .o_ctrl_rd_req(o_ctrl_rd_req),
      .o_ctrl_wr_addr(o_ctrl_wr_addr), .o_ctrl_rd_addr(o_ctrl_rd_addr),
      .o_ctrl_wr_data(o_ctrl_wr_data),
      .i_ctrl_ready(ctrl_ready), .i_ctrl_done(done), .i_ctrl_rd_data(crd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference rule: first valid port after 'last', wrapping.
   function automatic int rr_pick(input int last, input logic [NP-1:0] v);
      for (int k = 1; k <= NP; k++) begin
         if (v[(last + k) % NP]) return (last + k) % NP;
      end
      return -1;
   endfunction

   task automatic chk_zero(input string pfx);
      chk({pfx, "_ready"}, 32'(o_req_ready), 32'd0);
      chk({pfx, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
      chk({pfx, "_rd_data"}, 32'(o_rd_data), 32'd0);
      chk({pfx, "_err"}, 32'(o_err), 32'd0);
      chk({pfx, "_wr_req"}, 32'(o_ctrl_wr_req), 32'd0);
      chk({pfx, "_rd_req"}, 32'(o_ctrl_rd_req), 32'd0);
      chk({pfx, "_wr_addr"}, 32'(o_ctrl_wr_addr), 32'd0);
      chk({pfx, "_rd_addr"}, 32'(o_ctrl_rd_addr), 32'd0);
      chk({pfx, "_wr_data"}, 32'(o_ctrl_wr_data), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = '0;
      done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_g = NP - 1;
   endtask

   // One transaction, called at a negedge with the DUT idle and the request driven.
   // lat = cycles from command pulse to done (>=1); lat = 0 means never done (timeout).
   task automatic serve(input int ep, input int lat, input logic [DW-1:0] rdata, input bit drop);
      logic [NP-1:0] oh;
      logic          cmd_we;
      logic [AW-1:0] cmd_addr;
      logic [DW-1:0] cmd_wdata;
      oh        = NP'(1) << ep;
      cmd_we    = we[ep];
      cmd_addr  = addr[ep];
      cmd_wdata = wdata[ep];
      #1;
      chk("grant", 32'(o_req_ready), 32'(oh));
      @(negedge clk);
      if (drop) valid[ep] = 1'b0;
      #1;
      chk("ready_in_issue", 32'(o_req_ready), 32'd0);
      chk("wr_pulse", 32'(o_ctrl_wr_req), 32'(cmd_we));
      chk("rd_pulse", 32'(o_ctrl_rd_req), 32'(!cmd_we));
      if (cmd_we) begin
         chk("wr_addr", 32'(o_ctrl_wr_addr), 32'(cmd_addr));
         chk("wr_data", 32'(o_ctrl_wr_data), 32'(cmd_wdata));
      end else begin
         chk("rd_addr", 32'(o_ctrl_rd_addr), 32'(cmd_addr));
      end
      if (lat == 0) begin
         repeat (TO) @(negedge clk);
         #1;
         chk("err_early", 32'(o_err), 32'd0);
         chk("rv_early", 32'(o_rd_valid), 32'd0);
         @(negedge clk);
         #1;
         chk("to_err", 32'(o_err), 32'(oh));
         chk("to_rd_valid", 32'(o_rd_valid), cmd_we ? 32'd0 : 32'(oh));
         if (!cmd_we) chk("to_rd_data", 32'(o_rd_data), 32'd0);
      end else begin
         repeat (lat) @(negedge clk);
         chk("wait_pulse", 32'(o_ctrl_wr_req | o_ctrl_rd_req), 32'd0);
         done = 1'b1;
         crd  = rdata;
         #1;
         chk("rv_before_done", 32'(o_rd_valid), 32'd0);
         @(negedge clk);
         done = 1'b0;
         #1;
         chk("rd_valid", 32'(o_rd_valid), cmd_we ? 32'd0 : 32'(oh));
         chk("no_err", 32'(o_err), 32'd0);
         if (!cmd_we) chk("rd_data", 32'(o_rd_data), 32'(rdata));
      end
   endtask

   // Ready must never have more than one bit set.
   always @(negedge clk) begin
      #2;
      chk("ready_onehot0", 32'($onehot0(o_req_ready)), 32'd1);
   end

   initial begin
      int ep;
      int lat;
      int p0;
      rst = 1'b1; valid = '0; we = '0; addr = '0; wdata = '0;
      ctrl_ready = 1'b1; done = 1'b0; crd = '0;
      do_reset();
      #1;
      chk_zero("reset");

      // Single write from port 0.
      valid[0] = 1'b1; we[0] = 1'b1;
      addr[0] = pack_addr(12'd13, 8'd5, 2'd0); wdata[0] = 16'hA5C3;
      serve(0, 2, 16'h0000, 1'b1); last_g = 0;

      // Read from port 1 returns to port 1.
      valid[1] = 1'b1; we[1] = 1'b0; addr[1] = pack_addr(12'd13, 8'd5, 2'd0);
      serve(1, 3, 16'hA5C3, 1'b1); last_g = 1;

      // Contention from reset: strict alternation.
      do_reset();
      valid = 2'b11; we = 2'b10;
      addr[0] = 22'h00_1234; addr[1] = 22'h2A_0F0F;
      wdata[0] = 16'h1111; wdata[1] = 16'h2222;
      for (int k = 0; k < 6; k++) begin
         serve(k % 2, 1, 16'h1000 + 16'(k), 1'b0);
         last_g = k % 2;
      end
      valid = '0;

      // Controller busy holds off the grant.
      ctrl_ready = 1'b0;
      valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 22'h15_5555; wdata[0] = 16'h5A5A;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("busy_ready", 32'(o_req_ready), 32'd0);
         chk("busy_pulse", 32'(o_ctrl_wr_req | o_ctrl_rd_req), 32'd0);
      end
      ctrl_ready = 1'b1;
      serve(0, 2, 16'h0000, 1'b1); last_g = 0;

      // Timeout on a read, then a late done is ignored.
      valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 22'h0A_BCDE;
      serve(0, 0, 16'h0000, 1'b1); last_g = 0;
      done = 1'b1; crd = 16'hDEAD;
      @(negedge clk);
      done = 1'b0;
      #1;
      chk("late_done_rv", 32'(o_rd_valid), 32'd0);
      chk("late_done_err", 32'(o_err), 32'd0);

      // Reset in the middle of a read.
      valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 22'h31_2345;
      #1;
      chk("mid_grant", 32'(o_req_ready), 32'd2);
      @(negedge clk);
      valid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; last_g = NP - 1;
      #1;
      chk_zero("midrst");
      done = 1'b1; crd = 16'hBEEF;
      @(negedge clk);
      done = 1'b0;
      #1;
      chk("stale_done_rv", 32'(o_rd_valid), 32'd0);
      valid = 2'b11; we = 2'b01;
      addr[0] = 22'h01_0101; wdata[0] = 16'h7777; addr[1] = 22'h02_0202;
      serve(0, 1, 16'h0000, 1'b1); last_g = 0;
      serve(1, 2, 16'h4321, 1'b1); last_g = 1;

      // Randomized traffic against the round-robin rule.
      for (int it = 0; it < 30; it++) begin
         for (int p = 0; p < NP; p++) begin
            if (!valid[p] && ($urandom_range(0, 1) == 1)) begin
               valid[p] = 1'b1;
               we[p]    = 1'($urandom_range(0, 1));
               addr[p]  = 22'($urandom);
               wdata[p] = 16'($urandom);
            end
         end
         if (valid == '0) begin
            p0 = $urandom_range(0, NP - 1);
            valid[p0] = 1'b1; we[p0] = 1'b0; addr[p0] = 22'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            ctrl_ready = 1'b0;
            repeat (2) begin
               @(negedge clk);
               #1;
               chk("rnd_busy_ready", 32'(o_req_ready), 32'd0);
            end
            ctrl_ready = 1'b1;
         end
         ep = rr_pick(last_g, valid);
         last_g = ep;
         lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
         serve(ep, lat, 16'($urandom), 1'b1);
      end
      valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
